// File: rtl/key_input_pkg.sv
// Shared types and constants for the confirm-button / switch input conditioner.
package key_input_pkg;

    // Conditioner FSM states; encoding is fixed so the state can be probed by value.
    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StPressWait   = 3'd1,
        StHeld        = 3'd2,
        StLongHeld    = 3'd3,
        StReleaseWait = 3'd4
    } state_e;

    // Largest switch value that is a legal BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Defaults for a 50 MHz clock: 20 ms debounce, 2 s long press.
    localparam int unsigned DEBOUNCE_CYC_50MHZ = 1_000_000;
    localparam int unsigned LONG_CYC_50MHZ     = 100_000_000;

endpackage

// File: rtl/sync_chain.sv
// Plain multi-stage flop synchroniser with a configurable reset value.
module sync_chain #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/key_input_conditioner.sv
// Synchronises and debounces the confirm button, captures the switch digit on each accepted
// press and emits one-cycle digit / long-press strobes for the lock FSM.
module key_input_conditioner
    import key_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_50MHZ,
    parameter int unsigned LONG_CYC     = LONG_CYC_50MHZ,
    parameter int unsigned CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw_raw,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_invalid,
    output logic       long_press,
    output logic       btn_level
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    logic             btn_s;
    logic [3:0]       sw_s;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic             ret_long;  // state to resume if a release turns out to be a bounce

    // Button idles released (1) so reset does not look like a press.
    sync_chain #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_s)
    );

    sync_chain #(
        .WIDTH   (4),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (4'd0)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sw_s)
    );

    // Debounce FSM with hold/release counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            cnt           <= '0;
            rcnt          <= '0;
            ret_long      <= 1'b0;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            digit_invalid <= 1'b0;
            long_press    <= 1'b0;
            btn_level     <= 1'b0;
        end else begin
            digit_valid   <= 1'b0;
            digit_invalid <= 1'b0;
            long_press    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!btn_s) begin
                        state <= StPressWait;
                        cnt   <= CNT_ONE;
                    end
                end
                StPressWait: begin
                    if (btn_s) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= StHeld;
                        cnt           <= '0;
                        btn_level     <= 1'b1;
                        digit         <= sw_s;
                        digit_valid   <= (sw_s <= BCD_MAX);
                        digit_invalid <= (sw_s > BCD_MAX);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StHeld: begin
                    // cnt is left frozen while the release is being qualified.
                    if (btn_s) begin
                        state    <= StReleaseWait;
                        rcnt     <= CNT_ONE;
                        ret_long <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= StLongHeld;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StLongHeld: begin
                    if (btn_s) begin
                        state    <= StReleaseWait;
                        rcnt     <= CNT_ONE;
                        ret_long <= 1'b1;
                    end
                end
                StReleaseWait: begin
                    if (!btn_s) begin
                        state <= ret_long ? StLongHeld : StHeld;
                        rcnt  <= '0;
                    end else if (rcnt == DEB_LAST) begin
                        state     <= StIdle;
                        btn_level <= 1'b0;
                        cnt       <= '0;
                        rcnt      <= '0;
                    end else begin
                        rcnt <= rcnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= StIdle;
                    cnt       <= '0;
                    rcnt      <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: table of presses plus bounce and reset sequences, with
// expected strobes queued at stimulus time and matched when the DUT strobes.
module tb_key_input_conditioner;

    localparam int KIND_VALID   = 0;
    localparam int KIND_INVALID = 1;
    localparam int KIND_LONG    = 2;

    typedef struct {
        logic [3:0] sw;
        int         hold;
        bit         exp_valid;
        bit         exp_invalid;
        bit         exp_long;
        logic [3:0] exp_digit;
    } vec_t;

    typedef struct {
        int         kind;
        logic [3:0] digit;
        int         at;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic [3:0] sw_raw;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_invalid;
    logic       long_press;
    logic       btn_level;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    vec_t vecs[9];

    key_input_conditioner #(
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (10),
        .CNT_W        (27)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .sw_raw        (sw_raw),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .digit_invalid (digit_invalid),
        .long_press    (long_press),
        .btn_level     (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] d, input int at);
        ev_t ev;
        ev.kind  = kind;
        ev.digit = d;
        ev.at    = at;
        sb.push_back(ev);
    endtask

    task automatic take(input int kind);
        ev_t ev;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected no strobe", kind, cyc);
        end else begin
            ev = sb.pop_front();
            check("strobe_kind", kind, ev.kind);
            check("strobe_cycle", cyc, ev.at);
            check("strobe_digit", int'(digit), int'(ev.digit));
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (digit_valid && digit_invalid) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: valid=1 invalid=1, expected at most one (cycle %0d)",
                         cyc);
            end
            if (digit_valid)   take(KIND_VALID);
            if (digit_invalid) take(KIND_INVALID);
            if (long_press)    take(KIND_LONG);
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_digit"}, int'(digit), 0);
        check({name, "_valid"}, int'(digit_valid), 0);
        check({name, "_invalid"}, int'(digit_invalid), 0);
        check({name, "_long"}, int'(long_press), 0);
        check({name, "_level"}, int'(btn_level), 0);
    endtask

    task automatic drain_check(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // One clean or glitchy press: btn_n low at edges e..e+hold-1.
    task automatic run_press(input vec_t v);
        int e;
        int rel;
        bit acc;
        acc = v.exp_valid || v.exp_invalid;
        @(negedge clk);
        sw_raw = v.sw;
        btn_n  = 1'b0;
        e      = cyc + 1;
        if (v.exp_valid)   push(KIND_VALID, v.exp_digit, e + 5);
        if (v.exp_invalid) push(KIND_INVALID, v.exp_digit, e + 5);
        if (v.exp_long)    push(KIND_LONG, v.exp_digit, e + 15);
        rel = 0;
        while (rel < v.hold + 10) begin
            @(negedge clk);
            rel = cyc - e;
            if (acc && rel == 5)           check("level_after_accept", int'(btn_level), 1);
            if (acc && rel == v.hold + 4)  check("level_before_release", int'(btn_level), 1);
            if (rel == v.hold + 5)         check("level_after_release", int'(btn_level), 0);
            if (rel == 6 && v.hold > 6)    sw_raw = ~v.sw;
            if (rel == v.hold - 1)         btn_n = 1'b1;
        end
        check("digit_hold", int'(digit), int'(v.exp_digit));
        drain_check("scoreboard_drained");
    endtask

    // Release bounce: high 2, low 1, then high; btn_level must fall once, late.
    task automatic run_bounce();
        int e;
        int rel;
        @(negedge clk);
        sw_raw = 4'd6;
        btn_n  = 1'b0;
        e      = cyc + 1;
        push(KIND_VALID, 4'd6, e + 5);
        rel = 0;
        while (rel < 25) begin
            @(negedge clk);
            rel = cyc - e;
            if (rel >= 5 && rel <= 15) check("bounce_level_high", int'(btn_level), 1);
            if (rel >= 16)             check("bounce_level_low", int'(btn_level), 0);
            if (rel == 7)  btn_n = 1'b1;
            if (rel == 9)  btn_n = 1'b0;
            if (rel == 10) btn_n = 1'b1;
        end
        check("bounce_digit", int'(digit), 6);
        drain_check("bounce_drained");
    endtask

    // Reset while HELD with the button still down; the press must re-debounce from scratch.
    task automatic run_reset_mid();
        int e;
        int rel;
        @(negedge clk);
        sw_raw = 4'd2;
        btn_n  = 1'b0;
        e      = cyc + 1;
        push(KIND_VALID, 4'd2, e + 5);
        rel = 0;
        while (rel < 8) begin
            @(negedge clk);
            rel = cyc - e;
        end
        check("pre_reset_level", int'(btn_level), 1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        drain_check("reset_drained");
        rst = 1'b0;
        e   = cyc + 1;
        push(KIND_VALID, 4'd2, e + 5);
        rel = 0;
        while (rel < 20) begin
            @(negedge clk);
            rel = cyc - e;
            if (rel == 4)  check("redebounce_level_low", int'(btn_level), 0);
            if (rel == 5)  check("redebounce_level_high", int'(btn_level), 1);
            if (rel == 7)  btn_n = 1'b1;
            if (rel == 13) check("post_reset_release_level", int'(btn_level), 0);
        end
        check("post_reset_digit", int'(digit), 2);
        drain_check("post_reset_drained");
    endtask

    initial begin
        rst    = 1'b1;
        btn_n  = 1'b1;
        sw_raw = 4'd0;

        //          sw     hold val inv long digit
        vecs[0] = '{4'd5,  20,  1,  0,  1,   4'd5};
        vecs[1] = '{4'd3,  2,   0,  0,  0,   4'd5};
        vecs[2] = '{4'hC,  8,   0,  1,  0,   4'hC};
        vecs[3] = '{4'd9,  30,  1,  0,  1,   4'd9};
        vecs[4] = '{4'd0,  4,   1,  0,  0,   4'd0};
        vecs[5] = '{4'd7,  3,   0,  0,  0,   4'd0};
        vecs[6] = '{4'hA,  13,  0,  1,  0,   4'hA};
        vecs[7] = '{4'd3,  14,  1,  0,  1,   4'd3};
        vecs[8] = '{4'hF,  6,   0,  1,  0,   4'hF};

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle_after_reset");

        for (int i = 0; i < 9; i++) begin
            run_press(vecs[i]);
        end
        run_bounce();
        run_reset_mid();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
